divergence_ctrl: RTL
====================

// Module: divergence_ctrl
// PURPOSE
//  Issuing-side controller for the SIMT predicate stack (pstack). Decodes IF/ELSE/ENDIF
//  control instructions from the scheduler against per-core predicate bits.
//  Maintains the live active-thread mask and drives pstack push/pop/d.
//  Sits between the instruction decoder and pstack; active_mask gates core writeback.
// PARAMETERS
//  N_CORES      `N_CORES (4)   lanes; width of masks and predicates
//  STACK_DEPTH  `STACK_DEPTH (3)  pstack pointer width; max nesting = 2**STACK_DEPTH-1
// PORTS
//  clk            in   1        single clock, all state on rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  instr_valid    in   1        control instruction offered
//  instr_ready    out  1        controller can accept (IDLE state only)
//  instr_op       in   2        00 NOP, 01 IF, 10 ELSE, 11 ENDIF
//  pred           in   N_CORES  per-core branch predicate, sampled on accept
//  active_mask    out  N_CORES  current active lanes (1 = executing)
//  stk_push       out  1        to pstack.push
//  stk_pop        out  1        to pstack.pop
//  stk_comp       out  1        to pstack.comp; held 0 (reserved)
//  stk_d          out  N_CORES  to pstack.d
//  stk_q          in   N_CORES  from pstack.q (registered top-of-stack)
//  depth          out  STACK_DEPTH  current nesting level
//  err_overflow   out  1        sticky: IF at max depth
//  err_underflow  out  1        sticky: ELSE/ENDIF at depth 0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, active_mask=all 1s, depth=0, stk_*=0,
//   stk_d=0, errors=0, instr_ready=1. Reset mid-operation aborts any command; the
//   pstack is reset alongside and holds 0 at its base.
//  FSM: IDLE -> ISSUE -> SETTLE -> IDLE. instr_ready=1 only in IDLE.
//   Accept = instr_valid & instr_ready at a rising edge; NOP accepted, stays in IDLE.
//   ISSUE: stk_push/stk_pop high for exactly this one cycle (registered outputs).
//   SETTLE: one cycle for pstack q to update; stk_q is valid again in IDLE.
//   Throughput: one IF/ELSE/ENDIF per 3 cycles; NOP one per cycle.
//  IF (on accept): stk_d<=active_mask; active_mask<=active_mask & pred;
//   depth<=depth+1; push in ISSUE.
//  ELSE (on accept): active_mask<=stk_q & ~active_mask (lanes of parent not taken);
//   no stack command; ISSUE/SETTLE still traversed (uniform timing).
//  ENDIF (on accept): active_mask<=stk_q; depth<=depth-1; pop in ISSUE.
//  Boundaries: IF at depth=2**STACK_DEPTH-1 -> no push, mask/depth unchanged,
//   err_overflow<=1. ELSE/ENDIF at depth=0 -> no pop, mask unchanged, err_underflow<=1.
//   Errored instructions still consumed (3-cycle path, no command). Errors sticky to reset.
//  pred lanes where active_mask=0 are ignored (AND). All-zero masks are legal.
//  stk_push and stk_pop never asserted together; stk_comp constant 0.
// CONFIGURATION
//  DIVERGE_EMPTY_FLAG_EN defined: adds output skip_req (1) asserted from IDLE
//   onward whenever active_mask==0 and depth>0, so fetch may jump to matching ELSE/ENDIF;
//   deasserts the cycle after active_mask becomes nonzero or on reset (0 at reset).
//  Undefined: port skip_req absent; all-zero mask simply idles lanes.
// TESTING (N_CORES=4, STACK_DEPTH=3, pstack instantiated as stack model)
//  Reset: pulse reset_n low mid-ISSUE -> active_mask=4'b1111, depth=0, stk_push=0 async.
//  IF pred=4'b0101 -> stk_d=4'b1111, push 1 cycle, active_mask=4'b0101, depth=1, ready after 3 cycles.
//  Then ELSE -> active_mask=4'b1010; ENDIF -> active_mask=4'b1111, pop 1 cycle, depth=0.
//  Nested IF 0011 then IF 0110 -> masks 0011, 0010; ENDIF,ENDIF -> 0011, 1111.
//  8 IFs from depth 0 -> depth=7, 8th gives err_overflow=1, no push; ENDIF at depth 0 -> err_underflow=1.
//  EMPTY_FLAG_EN: IF pred=4'b0000 -> skip_req=1; ELSE -> mask 1111, skip_req=0.

Source files
------------

// File: rtl/divergence_ctrl.sv
// divergence_ctrl: issues IF/ELSE/ENDIF against the SIMT predicate stack and tracks the active lane mask.
// Optional DIVERGE_EMPTY_FLAG_EN adds skip_req for all-lanes-off regions.
module divergence_ctrl #(
  parameter int N_CORES     = 4,
  parameter int STACK_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [1:0]             instr_op,
  input  logic [N_CORES-1:0]     pred,
  output logic [N_CORES-1:0]     active_mask,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_comp,
  output logic [N_CORES-1:0]     stk_d,
  input  logic [N_CORES-1:0]     stk_q,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   err_overflow,
  output logic                   err_underflow
`ifdef DIVERGE_EMPTY_FLAG_EN
  ,
  output logic                   skip_req
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
  localparam logic [1:0] OP_NOP = 2'b00, OP_IF = 2'b01, OP_ELSE = 2'b10, OP_ENDIF = 2'b11;
  state_t state, state_nxt;
  logic acc, is_if, is_else, is_endif, full, empty, do_push, do_pop, do_else;
  assign instr_ready = state == IDLE;
  assign stk_comp    = 1'b0;
  assign acc         = instr_valid & instr_ready;
  assign is_if       = acc && instr_op == OP_IF;
  assign is_else     = acc && instr_op == OP_ELSE;
  assign is_endif    = acc && instr_op == OP_ENDIF;
  assign full        = depth == '1;
  assign empty       = depth == '0;
  assign do_push     = is_if & ~full;
  assign do_pop      = is_endif & ~empty;
  assign do_else     = is_else & ~empty;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == ISSUE  ? SETTLE :
                state == SETTLE ? IDLE   :
                (acc && instr_op != OP_NOP) ? ISSUE : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end
  // stack commands are registered so they land exactly in ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_mask   <= '1;
      depth         <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_d         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      stk_push <= do_push;
      stk_pop  <= do_pop;
      if (do_push) begin
        stk_d       <= active_mask;
        active_mask <= active_mask & pred;
        depth       <= depth + 1'b1;
      end else if (do_else) begin
        active_mask <= stk_q & ~active_mask;
      end else if (do_pop) begin
        active_mask <= stk_q;
        depth       <= depth - 1'b1;
      end
      if (is_if & full) err_overflow <= 1'b1;
      if ((is_else | is_endif) & empty) err_underflow <= 1'b1;
    end
  end
`ifdef DIVERGE_EMPTY_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) skip_req <= 1'b0;
    else          skip_req <= active_mask == '0 && depth != '0;
  end
`endif
endmodule
